// File: rtl/fetch_queue.sv
// fetch_queue: issues one fetch at a time and buffers up to two {pc, instr} pairs for decode
module fetch_queue #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        o_enable,
  output logic [31:0] o_pc,
  output logic        o_we,
  output logic [31:0] o_value,
  input  logic [31:0] i_instruction,
  input  logic        i_completed,
  output logic        o_valid,
  output logic [31:0] o_instr,
  output logic [31:0] o_instr_pc,
  input  logic        i_ready,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DROP} state_t;
  state_t      state, state_n;
  logic [31:0] pc;
  logic [1:0]  count, count_ap;
  logic [63:0] ent [2];
  logic        armed, pop, push;
  assign pop      = o_valid & i_ready & ~i_redirect;
  assign push     = (state == WAIT) & i_completed & ~i_redirect;
  assign count_ap = count - {1'b0, pop};
  // state register; armed delays the first issue until the second edge after reset release
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      armed <= 1'b0;
    end else begin
      state <= state_n;
      armed <= 1'b1;
    end
  // next state: one fetch in flight at most; a redirected fetch is drained in DROP
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = (armed && !i_redirect && count_ap < 2'd2) ? ISSUE : IDLE;
      ISSUE:   state_n = i_redirect ? DROP : WAIT;
      WAIT:    state_n = i_completed ? IDLE : (i_redirect ? DROP : WAIT);
      default: state_n = i_completed ? IDLE : DROP;
    endcase
  end
  // outputs: fetch request only in ISSUE, write port unused, head of queue to decode
  always_comb begin
    o_enable   = (state == ISSUE);
    o_pc       = pc;
    o_we       = 1'b0;
    o_value    = 32'h0;
    o_valid    = (count != 2'd0);
    o_instr    = ent[0][31:0];
    o_instr_pc = ent[0][63:32];
  end
  // pc and queue: redirect flushes and wins over any same-cycle pop or push
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      pc     <= RESET_PC;
      count  <= 2'd0;
      ent[0] <= 64'h0;
      ent[1] <= 64'h0;
    end else begin
      pc    <= i_redirect ? (i_redirect_pc & 32'hFFFF_FFFC) : (push ? pc + 32'd4 : pc);
      count <= i_redirect ? 2'd0 : count_ap + {1'b0, push};
      if (pop) ent[0] <= ent[1];
      if (push) ent[count_ap[0]] <= {pc, i_instruction};
    end
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed vector table, reset/wrap sequences and randomized run against a queue model
module tb_fetch_queue;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, ready, comp, redir;
  logic [31:0] ins, rpc;
  logic        en, we, valid;
  logic [31:0] pc, value, instr, ipc;

  logic        w_reset, w_comp, w_ready, w_redir;
  logic [31:0] w_ins, w_rpc;
  logic        w_en, w_we, w_valid;
  logic [31:0] w_pc, w_value, w_instr, w_ipc;

  fetch_queue dut (
    .clk(clk), .reset(reset), .o_enable(en), .o_pc(pc), .o_we(we), .o_value(value),
    .i_instruction(ins), .i_completed(comp), .o_valid(valid), .o_instr(instr),
    .o_instr_pc(ipc), .i_ready(ready), .i_redirect(redir), .i_redirect_pc(rpc)
  );

  fetch_queue #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .reset(w_reset), .o_enable(w_en), .o_pc(w_pc), .o_we(w_we), .o_value(w_value),
    .i_instruction(w_ins), .i_completed(w_comp), .o_valid(w_valid), .o_instr(w_instr),
    .o_instr_pc(w_ipc), .i_ready(w_ready), .i_redirect(w_redir), .i_redirect_pc(w_rpc)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", n, act, exp);
    end
  endtask

  typedef struct {
    logic        rdy, cmp;
    logic [31:0] ins;
    logic        rd;
    logic [31:0] rp;
    logic        e;
    logic [31:0] p;
    logic        v;
    logic [31:0] ei, eip;
  } vec_t;

  function automatic vec_t mk(logic rdy, logic cmp, logic [31:0] i, logic rd, logic [31:0] rp,
                              logic e, logic [31:0] p, logic v, logic [31:0] ei, logic [31:0] eip);
    vec_t t;
    t.rdy = rdy; t.cmp = cmp; t.ins = i; t.rd = rd; t.rp = rp;
    t.e = e; t.p = p; t.v = v; t.ei = ei; t.eip = eip;
    return t;
  endfunction

  // reference model: a queue of fetched words plus the progress of the single outstanding fetch
  logic [63:0] m_q [$];
  logic [31:0] m_pc;
  bit          m_issuing, m_busy, m_stale, m_armed;

  task automatic m_reset(input logic [31:0] rst_pc);
    m_q.delete();
    m_pc = rst_pc;
    m_issuing = 0; m_busy = 0; m_stale = 0; m_armed = 0;
  endtask

  task automatic m_step(input logic rdy, input logic cmp, input logic [31:0] i,
                        input logic rd, input logic [31:0] rp);
    bit pop, idle, push;
    pop  = (m_q.size() != 0) && rdy && !rd;
    idle = !m_issuing && !m_busy;
    push = 0;
    if (m_issuing) begin
      m_issuing = 0; m_busy = 1; m_stale = rd;
    end else if (m_busy) begin
      if (cmp) begin
        m_busy = 0;
        push = !m_stale && !rd;
      end else if (rd) m_stale = 1;
    end
    if (rd) m_q.delete();
    else if (pop) void'(m_q.pop_front());
    if (push) begin
      if (m_q.size() >= 2) begin
        errors++;
        $display("FAIL push_at_full got size %0d want below 2", m_q.size());
      end
      m_q.push_back({m_pc, i});
      m_pc = m_pc + 32'd4;
    end
    if (rd) m_pc = {rp[31:2], 2'b00};
    if (idle && m_armed && !rd && m_q.size() < 2) m_issuing = 1;
    m_armed = 1;
  endtask

  task automatic drive(input logic rdy, input logic cmp, input logic [31:0] i,
                       input logic rd, input logic [31:0] rp);
    ready = rdy; comp = cmp; ins = i; redir = rd; rpc = rp;
  endtask

  vec_t tbl [28];
  bit   pend;
  int   lat;
  logic r_rdy, r_cmp, r_rd;
  logic [31:0] r_ins, r_rp;
  bit   seen;

  initial begin
    reset = 1'b0; w_reset = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    w_comp = 1'b0; w_ins = 32'h0; w_ready = 1'b1; w_redir = 1'b0; w_rpc = 32'h0;

    tbl[0]  = mk(1'b0, 1'b0, 32'h0,    1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0,  32'h0);
    tbl[1]  = mk(1'b0, 1'b0, 32'h0,    1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0,  32'h0);
    tbl[2]  = mk(1'b0, 1'b0, 32'h0,    1'b0, 32'h0,   1'b1, 32'h0,   1'b0, 32'h0,  32'h0);
    tbl[3]  = mk(1'b0, 1'b0, 32'h0,    1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0,  32'h0);
    tbl[4]  = mk(1'b0, 1'b1, 32'hA0,   1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0,  32'h0);
    tbl[5]  = mk(1'b0, 1'b0, 32'h0,    1'b0, 32'h0,   1'b0, 32'h4,   1'b1, 32'hA0, 32'h0);
    tbl[6]  = mk(1'b0, 1'b0, 32'h0,    1'b0, 32'h0,   1'b1, 32'h4,   1'b1, 32'hA0, 32'h0);
    tbl[7]  = mk(1'b0, 1'b0, 32'h0,    1'b0, 32'h0,   1'b0, 32'h4,   1'b1, 32'hA0, 32'h0);
    tbl[8]  = mk(1'b0, 1'b1, 32'hA1,   1'b0, 32'h0,   1'b0, 32'h4,   1'b1, 32'hA0, 32'h0);
    tbl[9]  = mk(1'b0, 1'b0, 32'h0,    1'b0, 32'h0,   1'b0, 32'h8,   1'b1, 32'hA0, 32'h0);
    tbl[10] = mk(1'b1, 1'b0, 32'h0,    1'b0, 32'h0,   1'b0, 32'h8,   1'b1, 32'hA0, 32'h0);
    tbl[11] = mk(1'b1, 1'b0, 32'h0,    1'b0, 32'h0,   1'b1, 32'h8,   1'b1, 32'hA1, 32'h4);
    tbl[12] = mk(1'b1, 1'b0, 32'h0,    1'b0, 32'h0,   1'b0, 32'h8,   1'b0, 32'h0,  32'h0);
    tbl[13] = mk(1'b1, 1'b1, 32'hA2,   1'b0, 32'h0,   1'b0, 32'h8,   1'b0, 32'h0,  32'h0);
    tbl[14] = mk(1'b1, 1'b0, 32'h0,    1'b0, 32'h0,   1'b0, 32'hC,   1'b1, 32'hA2, 32'h8);
    tbl[15] = mk(1'b0, 1'b0, 32'h0,    1'b0, 32'h0,   1'b1, 32'hC,   1'b0, 32'h0,  32'h0);
    tbl[16] = mk(1'b0, 1'b0, 32'h0,    1'b1, 32'h103, 1'b0, 32'hC,   1'b0, 32'h0,  32'h0);
    tbl[17] = mk(1'b0, 1'b1, 32'hDEAD, 1'b0, 32'h0,   1'b0, 32'h100, 1'b0, 32'h0,  32'h0);
    tbl[18] = mk(1'b0, 1'b0, 32'h0,    1'b0, 32'h0,   1'b0, 32'h100, 1'b0, 32'h0,  32'h0);
    tbl[19] = mk(1'b0, 1'b0, 32'h0,    1'b0, 32'h0,   1'b1, 32'h100, 1'b0, 32'h0,  32'h0);
    tbl[20] = mk(1'b0, 1'b1, 32'hB0,   1'b0, 32'h0,   1'b0, 32'h100, 1'b0, 32'h0,  32'h0);
    tbl[21] = mk(1'b0, 1'b0, 32'h0,    1'b0, 32'h0,   1'b0, 32'h104, 1'b1, 32'hB0, 32'h100);
    tbl[22] = mk(1'b0, 1'b0, 32'h0,    1'b0, 32'h0,   1'b1, 32'h104, 1'b1, 32'hB0, 32'h100);
    tbl[23] = mk(1'b1, 1'b1, 32'hEE,   1'b1, 32'h200, 1'b0, 32'h104, 1'b1, 32'hB0, 32'h100);
    tbl[24] = mk(1'b0, 1'b1, 32'hFF,   1'b0, 32'h0,   1'b0, 32'h200, 1'b0, 32'h0,  32'h0);
    tbl[25] = mk(1'b0, 1'b1, 32'hFF,   1'b0, 32'h0,   1'b1, 32'h200, 1'b0, 32'h0,  32'h0);
    tbl[26] = mk(1'b0, 1'b1, 32'hC0,   1'b0, 32'h0,   1'b0, 32'h200, 1'b0, 32'h0,  32'h0);
    tbl[27] = mk(1'b0, 1'b0, 32'h0,    1'b0, 32'h0,   1'b0, 32'h204, 1'b1, 32'hC0, 32'h200);

    repeat (2) @(negedge clk);
    reset = 1'b1;
    for (int r = 0; r < 28; r++) begin
      chk($sformatf("tbl%0d_enable", r), 32'(en), 32'(tbl[r].e));
      if (tbl[r].e) chk($sformatf("tbl%0d_pc", r), pc, tbl[r].p);
      chk($sformatf("tbl%0d_valid", r), 32'(valid), 32'(tbl[r].v));
      if (tbl[r].v) begin
        chk($sformatf("tbl%0d_instr", r), instr, tbl[r].ei);
        chk($sformatf("tbl%0d_instr_pc", r), ipc, tbl[r].eip);
      end
      chk($sformatf("tbl%0d_we_value", r), {31'(value), we}, 32'h0);
      drive(tbl[r].rdy, tbl[r].cmp, tbl[r].ins, tbl[r].rd, tbl[r].rp);
      @(negedge clk);
    end

    // reset pulse while a fetch is outstanding, then a stray completion after release
    @(negedge clk);
    chk("midwait_valid_before", 32'(valid), 32'h1);
    chk("midwait_enable_before", 32'(en), 32'h0);
    #2 reset = 1'b0;
    #1;
    chk("rst_enable", 32'(en), 32'h0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_valid", 32'(valid), 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_instr_pc", ipc, 32'h0);
    chk("rst_we_value", {31'(value), we}, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    drive(1'b1, 1'b1, 32'h77, 1'b0, 32'h0);
    @(negedge clk);
    drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("stray_valid", 32'(valid), 32'h0);
    chk("first_edge_no_issue", 32'(en), 32'h0);
    @(negedge clk);
    chk("second_edge_issue", 32'(en), 32'h1);
    chk("second_edge_pc", pc, 32'h0);
    chk("stray_valid_later", 32'(valid), 32'h0);

    // randomized run against the model
    reset = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    m_reset(32'h0);
    pend = 0; lat = 0;
    for (int c = 0; c < 3000; c++) begin
      chk("rnd_enable", 32'(en), 32'(m_issuing));
      if (m_issuing) chk("rnd_pc", pc, m_pc);
      chk("rnd_valid", 32'(valid), 32'(m_q.size() != 0));
      if (m_q.size() != 0) begin
        chk("rnd_instr", instr, m_q[0][31:0]);
        chk("rnd_instr_pc", ipc, m_q[0][63:32]);
      end
      r_cmp = 1'b0;
      if (pend) begin
        if (lat == 0) begin
          r_cmp = 1'b1;
          pend = 0;
        end else lat--;
      end
      if (en) begin
        pend = 1;
        lat = int'($urandom_range(0, 3));
      end
      if (!r_cmp && $urandom_range(0, 19) == 0) r_cmp = 1'b1;
      r_rdy = ($urandom_range(0, 9) < 6);
      r_rd  = ($urandom_range(0, 24) == 0);
      r_ins = $urandom();
      r_rp  = $urandom();
      drive(r_rdy, r_cmp, r_ins, r_rd, r_rp);
      m_step(r_rdy, r_cmp, r_ins, r_rd, r_rp);
      @(negedge clk);
    end
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);

    // pc wrap from the top of the address space
    w_reset = 1'b1;
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      seen = w_en;
    end
    chk("wrap_first_issue_seen", 32'(seen), 32'h1);
    chk("wrap_first_pc", w_pc, 32'hFFFF_FFFC);
    @(negedge clk);
    w_comp = 1'b1; w_ins = 32'h11;
    @(negedge clk);
    w_comp = 1'b0;
    chk("wrap_head_valid", 32'(w_valid), 32'h1);
    chk("wrap_head_pc", w_ipc, 32'hFFFF_FFFC);
    chk("wrap_head_instr", w_instr, 32'h11);
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      seen = w_en;
    end
    chk("wrap_second_issue_seen", 32'(seen), 32'h1);
    chk("wrap_second_pc", w_pc, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
